muon_decay_sequencer: RTL and testbench

Acquisition controller for the muon-decay double-pulse path.
- Edge-detects the discriminator trigger.
- Arms a coincidence window and timestamps the second (decay) pulse.
- Enforces a programmable dead time after each capture.
- Hands each event to the PS readout through a single-entry valid/ack buffer.
- Keeps saturating run statistics.

Sits between the fast-comparator trigger line and the AXI-GPIO register block.

---
 rtl/muon_decay_sequencer_pkg.sv | 16 +
 rtl/muon_decay_sequencer_edge.sv | 27 ++
 rtl/muon_decay_sequencer.sv | 147 ++++++++++++++
 tb/tb_muon_decay_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muon_decay_sequencer_pkg.sv
// Shared definitions for the muon-decay acquisition path.
// No logic: state encoding and default widths only.
// No flow control.
package muon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WINDOW  = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam int CNT_W_DEF  = 16;
  localparam int STAT_W_DEF = 32;

endpackage

// File: rtl/muon_decay_sequencer_edge.sv
// Rising-edge detector on a raw trigger line: 3-flop shift register, edge = q1 & q2 & ~q3.
// Latency: pulse_o asserts 2 cycles after the input rises; input must stay high 2 cycles.
// No flow control: pulse_o is a single-cycle strobe.
module pulse_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse_o
);

  logic [2:0] sr_q;
  logic [2:0] sr_d;

  // Shift the raw input through three stages; sr[0] is q1.
  always_comb begin
    sr_d = {sr_q[1:0], din};
  end

  // Shift register state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) sr_q <= 3'b000;
    else     sr_q <= sr_d;
  end

  assign pulse_o = sr_q[0] & sr_q[1] & ~sr_q[2];

endmodule

// File: rtl/muon_decay_sequencer.sv
// Double-pulse acquisition controller: coincidence window, dead time, single-entry event buffer, run stats.
// Latency: capture visible on evt_valid 1 cycle after the second edge is detected (edge itself lags trigger by 2).
// Backpressure: one-entry buffer; a capture while full and unacked is dropped and counted in lost_cnt.
module muon_decay_sequencer
  import muon_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_stats,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  window,
  input  logic [CNT_W-1:0]  holdoff,
  output logic              evt_valid,
  output logic [CNT_W-1:0]  evt_delta,
  input  logic              rd_ack,
  output logic              busy,
  output logic [STAT_W-1:0] single_cnt,
  output logic [STAT_W-1:0] double_cnt,
  output logic [STAT_W-1:0] lost_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic               evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0]   evt_delta_q, evt_delta_d;
  logic               busy_q, busy_d;
  logic [STAT_W-1:0]  single_q, single_d;
  logic [STAT_W-1:0]  double_q, double_d;
  logic [STAT_W-1:0]  lost_q, lost_d;

  logic trig_rise;
  logic capture;
  logic single_inc;
  logic lost_inc;

  pulse_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .din     (trigger),
    .pulse_o (trig_rise)
  );

  function automatic logic [STAT_W-1:0] sat_bump(input logic [STAT_W-1:0] v, input logic inc);
    return (inc && (v != {STAT_W{1'b1}})) ? v + STAT_ONE : v;
  endfunction

  // Next-state logic: disable overrides everything; WINDOW checks capture before expiry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    capture    = 1'b0;
    single_inc = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (trig_rise) begin
            state_d = WINDOW;
            cnt_d   = CNT_ONE;
          end
        end
        WINDOW: begin
          if (trig_rise && (cnt_q < window)) begin
            capture = 1'b1;
            state_d = HOLDOFF;
            hcnt_d  = '0;
          end else if (cnt_q >= window) begin
            single_inc = 1'b1;
            state_d    = ARMED;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HOLDOFF: begin
          if (hcnt_q >= holdoff) state_d = ARMED;
          else                   hcnt_d  = hcnt_q + CNT_ONE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == WINDOW) || (state_d == HOLDOFF);
  end

  // Event buffer and saturating statistics; an ack in the capture cycle frees the slot for the new event.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_delta_d = evt_delta_q;
    lost_inc    = 1'b0;
    if (capture) begin
      if (!evt_valid_q || rd_ack) begin
        evt_valid_d = 1'b1;
        evt_delta_d = cnt_q;
      end else begin
        lost_inc = 1'b1;
      end
    end else if (rd_ack) begin
      evt_valid_d = 1'b0;
    end
    single_d = clr_stats ? '0 : sat_bump(single_q, single_inc);
    double_d = clr_stats ? '0 : sat_bump(double_q, capture);
    lost_d   = clr_stats ? '0 : sat_bump(lost_q, lost_inc);
  end

  // All sequencer state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_delta_q <= '0;
      busy_q      <= 1'b0;
      single_q    <= '0;
      double_q    <= '0;
      lost_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      evt_valid_q <= evt_valid_d;
      evt_delta_q <= evt_delta_d;
      busy_q      <= busy_d;
      single_q    <= single_d;
      double_q    <= double_d;
      lost_q      <= lost_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_delta  = evt_delta_q;
  assign busy       = busy_q;
  assign single_cnt = single_q;
  assign double_cnt = double_q;
  assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_muon_decay_sequencer.sv
// Directed bench for muon_decay_sequencer: event table plus hand-written corner sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Stats width reduced to 8 bits so saturation is reachable quickly.
module tb_muon_decay_sequencer;

  localparam int CW = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clr_stats;
  logic          trigger;
  logic [CW-1:0] window;
  logic [CW-1:0] holdoff;
  logic          evt_valid;
  logic [CW-1:0] evt_delta;
  logic          rd_ack;
  logic          busy;
  logic [SW-1:0] single_cnt;
  logic [SW-1:0] double_cnt;
  logic [SW-1:0] lost_cnt;

  muon_decay_sequencer #(.CNT_W(CW), .STAT_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clr_stats  (clr_stats),
    .trigger    (trigger),
    .window     (window),
    .holdoff    (holdoff),
    .evt_valid  (evt_valid),
    .evt_delta  (evt_delta),
    .rd_ack     (rd_ack),
    .busy       (busy),
    .single_cnt (single_cnt),
    .double_cnt (double_cnt),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] win;
    logic [CW-1:0] hold;
    int            gap;        // cycles between first and second rising edge; 0 = single pulse
    bit            ack_cap;    // rd_ack during the capture cycle
    bit            ack_after;  // rd_ack pulse once the event has settled
    bit            exp_valid;
    int            exp_delta;
    int            exp_single;
    int            exp_double;
    int            exp_lost;
  } vec_t;

  vec_t tbl[10];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_hi(input int n);
    trigger = 1'b1;
    tick(n);
    trigger = 1'b0;
  endtask

  task automatic run_vec(input int i);
    window  = tbl[i].win;
    holdoff = tbl[i].hold;
    pulse_hi(4);
    if (tbl[i].gap != 0) begin
      tick(tbl[i].gap - 4);
      trigger = 1'b1;
      if (tbl[i].ack_cap) begin
        tick(2);
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      trigger = 1'b0;
    end
    tick(int'(tbl[i].win) + int'(tbl[i].hold) + 8);
    if (tbl[i].ack_after) begin
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      tick(1);
    end
    check($sformatf("v%0d evt_valid", i), 32'(evt_valid), 32'(tbl[i].exp_valid));
    check($sformatf("v%0d evt_delta", i), 32'(evt_delta), tbl[i].exp_delta);
    check($sformatf("v%0d single_cnt", i), 32'(single_cnt), tbl[i].exp_single);
    check($sformatf("v%0d double_cnt", i), 32'(double_cnt), tbl[i].exp_double);
    check($sformatf("v%0d lost_cnt", i), 32'(lost_cnt), tbl[i].exp_lost);
    check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
  endtask

  initial begin
    int bc;

    //             win    hold  gap ackc acka val delta sgl dbl lost
    tbl[0] = '{16'd1000, 16'd50, 100, 1'b0, 1'b1, 1'b0, 100, 0, 1, 0};
    tbl[1] = '{16'd20,   16'd50,   0, 1'b0, 1'b0, 1'b0, 100, 1, 1, 0};
    tbl[2] = '{16'd100,  16'd10,  30, 1'b0, 1'b0, 1'b1,  30, 1, 2, 0};
    tbl[3] = '{16'd100,  16'd10,  40, 1'b0, 1'b0, 1'b1,  30, 1, 3, 1};
    tbl[4] = '{16'd100,  16'd10,  40, 1'b1, 1'b0, 1'b1,  40, 1, 4, 1};
    tbl[5] = '{16'd100,  16'd0,   25, 1'b0, 1'b1, 1'b0,  40, 1, 5, 2};
    tbl[6] = '{16'd30,   16'd0,   30, 1'b0, 1'b0, 1'b0,  40, 2, 5, 2};
    tbl[7] = '{16'd31,   16'd5,   30, 1'b0, 1'b1, 1'b0,  30, 2, 6, 2};
    tbl[8] = '{16'd0,    16'd0,    0, 1'b0, 1'b1, 1'b0,  30, 3, 6, 2};
    tbl[9] = '{16'd1,    16'd0,   10, 1'b0, 1'b0, 1'b0,  30, 5, 6, 2};

    rst = 1'b1; enable = 1'b0; clr_stats = 1'b0; trigger = 1'b0; rd_ack = 1'b0;
    window = 16'd100; holdoff = 16'd10;
    tick(3);
    check("reset evt_valid", 32'(evt_valid), 32'd0);
    check("reset evt_delta", 32'(evt_delta), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset single_cnt", 32'(single_cnt), 32'd0);
    check("reset double_cnt", 32'(double_cnt), 32'd0);
    check("reset lost_cnt", 32'(lost_cnt), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick(2);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Fresh run for the corner sequences.
    rst = 1'b1; tick(1); rst = 1'b0; tick(2);

    // Single pulse, window 20: counter bumps exactly when cnt reaches the window.
    window = 16'd20; holdoff = 16'd0;
    pulse_hi(4);
    tick(18);
    check("single timing before", 32'(single_cnt), 32'd0);
    check("single busy before", 32'(busy), 32'd1);
    tick(1);
    check("single timing after", 32'(single_cnt), 32'd1);
    check("single busy after", 32'(busy), 32'd0);
    tick(3);

    // Double with delta 100 and holdoff 50: busy spans the window plus 51 dead-time cycles.
    window = 16'd1000; holdoff = 16'd50;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) bc++;
      trigger = (i < 4) || (i >= 100 && i < 104);
      tick(1);
    end
    check("busy cycle count", bc, 32'd151);
    check("h2 double_cnt", 32'(double_cnt), 32'd1);
    check("h2 evt_valid", 32'(evt_valid), 32'd1);
    check("h2 evt_delta", 32'(evt_delta), 32'd100);
    rd_ack = 1'b1; tick(1); rd_ack = 1'b0;
    check("h2 ack clears", 32'(evt_valid), 32'd0);
    tick(1);

    // Pulse inside a long holdoff is ignored; the next one after holdoff arms a window.
    window = 16'd100; holdoff = 16'd200;
    pulse_hi(4);
    tick(26);
    pulse_hi(4);
    check("h3 captured", 32'(evt_delta), 32'd30);
    check("h3 double", 32'(double_cnt), 32'd2);
    tick(49);
    pulse_hi(4);
    tick(63);
    check("h3 holdoff double", 32'(double_cnt), 32'd2);
    check("h3 holdoff single", 32'(single_cnt), 32'd1);
    check("h3 holdoff lost", 32'(lost_cnt), 32'd0);
    check("h3 still busy", 32'(busy), 32'd1);
    tick(90);
    trigger = 1'b1;
    tick(3);
    check("h3 rearmed window", 32'(busy), 32'd1);
    tick(1);
    trigger = 1'b0;
    tick(8);
    // Drop enable with cnt at 10: window discarded, buffer kept.
    enable = 1'b0;
    tick(1);
    check("disable to idle", 32'(busy), 32'd0);
    tick(150);
    check("disable single kept", 32'(single_cnt), 32'd1);
    check("disable buffer valid", 32'(evt_valid), 32'd1);
    check("disable buffer delta", 32'(evt_delta), 32'd30);

    // Re-enable, then reset in the middle of a window.
    enable = 1'b1;
    tick(2);
    pulse_hi(4);
    tick(8);
    rst = 1'b1;
    tick(1);
    check("rst evt_valid", 32'(evt_valid), 32'd0);
    check("rst evt_delta", 32'(evt_delta), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst single", 32'(single_cnt), 32'd0);
    check("rst double", 32'(double_cnt), 32'd0);
    check("rst lost", 32'(lost_cnt), 32'd0);
    rst = 1'b0;
    tick(2);

    // Clear coinciding with a single-count increment: clear wins.
    window = 16'd1;
    pulse_hi(2);
    tick(4);
    check("pre-clear single", 32'(single_cnt), 32'd1);
    window = 16'd20;
    pulse_hi(4);
    tick(18);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    check("clear beats inc", 32'(single_cnt), 32'd0);
    tick(3);

    // Saturation of the 8-bit single counter.
    window = 16'd1;
    for (int i = 0; i < 255; i++) begin
      pulse_hi(2);
      tick(2);
    end
    check("single at 255", 32'(single_cnt), 32'd255);
    for (int i = 0; i < 45; i++) begin
      pulse_hi(2);
      tick(2);
    end
    check("single saturated", 32'(single_cnt), 32'd255);
    check("sat double untouched", 32'(double_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
